// File: rtl/fp32_pkg.sv
// -----------------------------------------------------------------------------
// fp32_pkg
//   Shared constants for the iterative binary32 multiplier core:
//   field widths, exponent bias, internal exponent width, FSM state
//   encodings and a helper that forms the 24-bit significand of an operand.
// -----------------------------------------------------------------------------
package fp32_pkg;

    localparam int unsigned FP_BIAS = 127;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MAN_W   = 23;
    localparam int unsigned SIG_W   = 24;
    localparam int unsigned PROD_W  = 48;
    // Signed internal exponent: wide enough for eA+eB-127 (+2) without wrap.
    localparam int unsigned E_W     = 10;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MUL  = 3'd1;
    localparam logic [2:0] ST_NORM = 3'd2;
    localparam logic [2:0] ST_RND  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Hidden bit is 0 for a zero biased exponent (zero / denormal operand).
    function automatic logic [SIG_W-1:0] sig_of(input logic [EXP_W-1:0] e,
                                                input logic [MAN_W-1:0] f);
        return {|e, f};
    endfunction

endpackage

// File: rtl/seq_mant_mult.sv
// -----------------------------------------------------------------------------
// seq_mant_mult
//   Iterative unsigned 24x24 shift-add multiplier, BPC multiplier bits
//   retired per cycle, SIG_W/BPC cycles per product.
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start_i  in   load a_i/b_i and begin (ignored unless core is idle)
//   a_i      in   24-bit multiplicand
//   b_i      in   24-bit multiplier
//   busy_o   out  iteration in progress
//   done_o   out  final iteration is being performed this cycle;
//                 prod_o holds the full product from the next cycle on
//   prod_o   out  48-bit product register
// -----------------------------------------------------------------------------
module seq_mant_mult
    import fp32_pkg::*;
#(
    parameter int unsigned BPC = 1
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [SIG_W-1:0]  a_i,
    input  logic [SIG_W-1:0]  b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [PROD_W-1:0] prod_o
);

    localparam int unsigned N_ITER = SIG_W / BPC;
    localparam int unsigned CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;

    logic [PROD_W-1:0] mcand_q,  mcand_d;
    logic [SIG_W-1:0]  mplier_q, mplier_d;
    logic [PROD_W-1:0] acc_q,    acc_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              busy_q,   busy_d;
    logic [PROD_W-1:0] partial;

    always_comb begin
        // Sum of the multiplicand copies selected by the low BPC multiplier bits.
        partial = '0;
        for (int unsigned j = 0; j < BPC; j++) begin
            if (mplier_q[j]) begin
                partial = partial + (mcand_q << j);
            end
        end

        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;

        if (start_i && !busy_q) begin
            mcand_d  = {{(PROD_W-SIG_W){1'b0}}, a_i};
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = CNT_W'(N_ITER - 1);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_q + partial;
            mcand_d  = mcand_q << BPC;
            mplier_d = mplier_q >> BPC;
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == '0);
    assign prod_o = acc_q;

endmodule

// File: rtl/fp32_mult_core_seq.sv
// -----------------------------------------------------------------------------
// fp32_mult_core_seq
//   Iterative IEEE-754 binary32 multiplier core. Produces the raw product
//   (sign, exponent with overflow-to-Inf / flush-to-zero, RNE-rounded
//   mantissa) together with the operands as accepted. Inf/NaN/zero operand
//   cases are not resolved here; the downstream stage overrides them.
//   One operation in flight; accept only in IDLE.
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   A/B valid
//   in_ready   out  core idle, will accept A/B
//   A, B       in   binary32 operands (need not be held after accept)
//   out_valid  out  ansS/A_q/B_q valid, held until out_ready
//   out_ready  in   downstream consumes the result
//   ansS       out  raw product
//   A_q, B_q   out  operands as accepted
// -----------------------------------------------------------------------------
module fp32_mult_core_seq
    import fp32_pkg::*;
#(
    parameter int unsigned BPC = 1
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] ansS,
    output logic [31:0] A_q,
    output logic [31:0] B_q
);

    logic [2:0]              state_q,  state_d;
    logic [31:0]             opa_q,    opa_d;
    logic [31:0]             opb_q,    opb_d;
    logic                    sign_q,   sign_d;
    logic signed [E_W-1:0]   exp_q,    exp_d;
    logic [MAN_W-1:0]        frac_q,   frac_d;
    logic                    guard_q,  guard_d;
    logic                    round_q,  round_d;
    logic                    sticky_q, sticky_d;
    logic [31:0]             ans_q,    ans_d;

    logic                    accept;
    logic                    mult_busy;
    logic                    mult_done;
    logic [PROD_W-1:0]       prod;

    logic                    rnd_up;
    logic [MAN_W:0]          rnd_sum;
    logic signed [E_W-1:0]   exp_r;

    assign accept = in_valid && (state_q == ST_IDLE) && !mult_busy;

    // Mantissas are taken straight from A/B on the accept edge so the
    // multiplier runs in lock-step with the MUL state.
    seq_mant_mult #(
        .BPC (BPC)
    ) u_mant (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (accept),
        .a_i     (sig_of(A[30:23], A[22:0])),
        .b_i     (sig_of(B[30:23], B[22:0])),
        .busy_o  (mult_busy),
        .done_o  (mult_done),
        .prod_o  (prod)
    );

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        frac_d   = frac_q;
        guard_d  = guard_q;
        round_d  = round_q;
        sticky_d = sticky_q;
        ans_d    = ans_q;

        rnd_up   = guard_q & (round_q | sticky_q | frac_q[0]);
        rnd_sum  = {1'b0, frac_q} + {{MAN_W{1'b0}}, rnd_up};
        exp_r    = exp_q + (rnd_sum[MAN_W] ? 10'sd1 : 10'sd0);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    opa_d   = A;
                    opb_d   = B;
                    sign_d  = A[31] ^ B[31];
                    exp_d   = $signed({2'b00, A[30:23]} + {2'b00, B[30:23]}
                                      - E_W'(FP_BIAS));
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                if (mult_done) begin
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                // Product of two [1,2) significands lies in [1,4).
                if (prod[47]) begin
                    frac_d   = prod[46:24];
                    guard_d  = prod[23];
                    round_d  = prod[22];
                    sticky_d = |prod[21:0];
                    exp_d    = exp_q + 10'sd1;
                end else begin
                    frac_d   = prod[45:23];
                    guard_d  = prod[22];
                    round_d  = prod[21];
                    sticky_d = |prod[20:0];
                end
                state_d = ST_RND;
            end
            ST_RND: begin
                // A carry out of the mantissa leaves frac all-zero (1.0 x 2),
                // so only the exponent needs bumping.
                if (exp_r >= 10'sd255) begin
                    ans_d = {sign_q, 8'hFF, 23'h0};
                end else if (exp_r <= 10'sd0) begin
                    ans_d = {sign_q, 31'h0};
                end else begin
                    ans_d = {sign_q, exp_r[7:0], rnd_sum[MAN_W-1:0]};
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            frac_q   <= '0;
            guard_q  <= 1'b0;
            round_q  <= 1'b0;
            sticky_q <= 1'b0;
            ans_q    <= '0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            frac_q   <= frac_d;
            guard_q  <= guard_d;
            round_q  <= round_d;
            sticky_q <= sticky_d;
            ans_q    <= ans_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign ansS      = ans_q;
    assign A_q       = opa_q;
    assign B_q       = opb_q;

endmodule

// File: tb/tb_fp32_mult_core_seq.sv
// -----------------------------------------------------------------------------
// tb_fp32_mult_core_seq
//   Two cores (BPC=1 and BPC=4) share all inputs; both accept together and the
//   faster one waits in DONE until out_ready. Directed vectors with
//   hand-computed products, handshake/stall behaviour and mid-op reset.
// -----------------------------------------------------------------------------
module tb_fp32_mult_core_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a, b;

    logic        in_ready_1, out_valid_1, in_ready_4, out_valid_4;
    logic [31:0] ans_1, aq_1, bq_1, ans_4, aq_4, bq_4;

    int          n_vec = 0;
    int          n_err = 0;

    fp32_mult_core_seq #(.BPC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_1),
        .A(a), .B(b), .out_valid(out_valid_1), .out_ready(out_ready),
        .ansS(ans_1), .A_q(aq_1), .B_q(bq_1)
    );

    fp32_mult_core_seq #(.BPC(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_4),
        .A(a), .B(b), .out_valid(out_valid_4), .out_ready(out_ready),
        .ansS(ans_4), .A_q(aq_4), .B_q(bq_4)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Called at a negedge with both cores idle; returns at a negedge with both
    // cores in DONE (out_ready held low).
    task automatic run_op(input string tag, input logic [31:0] opa,
                          input logic [31:0] opb, input logic [31:0] expv);
        int lat1;
        int lat4;
        lat1 = 0;
        lat4 = 0;
        in_valid = 1'b1;
        a = opa;
        b = opb;
        for (int cyc = 1; cyc <= 60 && (lat1 == 0 || lat4 == 0); cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (cyc == 1) begin
                in_valid = 1'b0;
                a = 32'hDEAD_BEEF;
                b = 32'h1234_5678;
                check_eq({tag, " in_ready busy1"}, {31'b0, in_ready_1}, 32'd0);
                check_eq({tag, " in_ready busy4"}, {31'b0, in_ready_4}, 32'd0);
            end
            if (out_valid_1 && lat1 == 0) lat1 = cyc;
            if (out_valid_4 && lat4 == 0) lat4 = cyc;
        end
        check_eq({tag, " latency1"}, lat1, 32'd27);
        check_eq({tag, " latency4"}, lat4, 32'd9);
        check_eq({tag, " ansS1"}, ans_1, expv);
        check_eq({tag, " ansS4"}, ans_4, expv);
        check_eq({tag, " A_q1"}, aq_1, opa);
        check_eq({tag, " B_q1"}, bq_1, opb);
        check_eq({tag, " A_q4"}, aq_4, opa);
        check_eq({tag, " B_q4"}, bq_4, opb);
    endtask

    // Consume the result with a competing in_valid that must not be taken.
    task automatic release_result(input string tag, input logic [31:0] opa,
                                  input logic [31:0] expv);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = 32'h4120_0000;
        b = 32'h4120_0000;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_eq({tag, " idle in_ready1"}, {31'b0, in_ready_1}, 32'd1);
        check_eq({tag, " idle in_ready4"}, {31'b0, in_ready_4}, 32'd1);
        check_eq({tag, " idle out_valid1"}, {31'b0, out_valid_1}, 32'd0);
        check_eq({tag, " no accept A_q1"}, aq_1, opa);
        check_eq({tag, " no accept A_q4"}, aq_4, opa);
        check_eq({tag, " held ansS1"}, ans_1, expv);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(negedge clk);
        check_eq("rst in_ready1", {31'b0, in_ready_1}, 32'd1);
        check_eq("rst out_valid1", {31'b0, out_valid_1}, 32'd0);
        check_eq("rst ansS1", ans_1, 32'h0);
        check_eq("rst A_q1", aq_1, 32'h0);
        check_eq("rst B_q1", bq_1, 32'h0);
        check_eq("rst in_ready4", {31'b0, in_ready_4}, 32'd1);
        check_eq("rst out_valid4", {31'b0, out_valid_4}, 32'd0);
        check_eq("rst ansS4", ans_4, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1.5 * 2.0 = 3.0
        run_op("t1", 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000);
        release_result("t1", 32'h3FC0_0000, 32'h4040_0000);

        // -1.0 * 2.0 = -2.0, then stall in DONE for 5 cycles
        run_op("t2", 32'hBF80_0000, 32'h4000_0000, 32'hC000_0000);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = 32'h3F80_0000 + i;
            b = 32'h4040_0000;
            @(posedge clk);
            @(negedge clk);
            check_eq("stall ansS1", ans_1, 32'hC000_0000);
            check_eq("stall ansS4", ans_4, 32'hC000_0000);
            check_eq("stall A_q1", aq_1, 32'hBF80_0000);
            check_eq("stall B_q4", bq_4, 32'h4000_0000);
            check_eq("stall in_ready1", {31'b0, in_ready_1}, 32'd0);
            check_eq("stall out_valid4", {31'b0, out_valid_4}, 32'd1);
        end
        in_valid = 1'b0;
        release_result("t2", 32'hBF80_0000, 32'hC000_0000);

        // Accept in the cycle immediately after returning to IDLE.
        // Rounding: bits below half -> truncate; above half -> round up.
        run_op("t3a", 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002);
        release_result("t3a", 32'h3F80_0001, 32'h3F80_0002);
        run_op("t3b", 32'h3FC0_0001, 32'h3FC0_0001, 32'h4010_0002);
        release_result("t3b", 32'h3FC0_0001, 32'h4010_0002);

        // Overflow to Inf, underflow flush to zero.
        run_op("t4a", 32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000);
        release_result("t4a", 32'h7F7F_FFFF, 32'h7F80_0000);
        run_op("t4b", 32'h0080_0000, 32'h3F00_0000, 32'h0000_0000);
        release_result("t4b", 32'h0080_0000, 32'h0000_0000);

        // -3 * -3 = 9 (product >= 2 path), and a rounding carry-out:
        // sig 0xFFF800 * 0x800400 = 2^47 - 2^21 -> rounds to exactly 2.0
        run_op("t_neg", 32'hC040_0000, 32'hC040_0000, 32'h4110_0000);
        release_result("t_neg", 32'hC040_0000, 32'h4110_0000);
        run_op("t_carry", 32'h3FFF_F800, 32'h3F80_0400, 32'h4000_0000);
        release_result("t_carry", 32'h3FFF_F800, 32'h4000_0000);

        // Reset during MUL iteration 10 of the BPC=1 core.
        in_valid = 1'b1;
        a = 32'h4040_0000;
        b = 32'h4040_0000;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (cyc == 1) begin
                in_valid = 1'b0;
                a = '0;
                b = '0;
            end
        end
        rst_n = 1'b0;
        #1;
        check_eq("midrst out_valid1", {31'b0, out_valid_1}, 32'd0);
        check_eq("midrst out_valid4", {31'b0, out_valid_4}, 32'd0);
        check_eq("midrst ansS1", ans_1, 32'h0);
        check_eq("midrst ansS4", ans_4, 32'h0);
        check_eq("midrst A_q1", aq_1, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("postrst in_ready1", {31'b0, in_ready_1}, 32'd1);
        check_eq("postrst in_ready4", {31'b0, in_ready_4}, 32'd1);
        check_eq("postrst out_valid1", {31'b0, out_valid_1}, 32'd0);

        run_op("t6", 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000);
        release_result("t6", 32'h3FC0_0000, 32'h4040_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
